uart_mem_loader: RTL

- Serial-command bus initiator. Takes bytes from the UART receive path and drives the same word-wide memory port the CPU uses on sram_ctrl, as a second master for boot loading and debug peek/poke.
- Parses 'W'/'R' frames, performs one SRAM word access per frame, and returns ACK or read data bytes to the UART transmit path.
- Sits beside the CPU. An external arbiter grants it the sram_ctrl memory port through bus_req_o/bus_gnt_i.

---
 rtl/uart_mem_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_mem_loader.sv
// UART-driven memory bus initiator: parses 'W'/'R' frames and performs one SRAM
// word access per frame on the shared sram_ctrl port, answering over the UART TX path.
module uart_mem_loader #(
  parameter int unsigned ACCESS_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic        busy_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic [3:0]  mem_be_n
);

  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned AccW = $clog2(ACCESS_CYCLES + 1);

  localparam logic [7:0] OpWrite = 8'h57;
  localparam logic [7:0] OpRead  = 8'h52;
  localparam logic [7:0] RspAck  = 8'h06;
  localparam logic [7:0] RspNak  = 8'h15;

  typedef enum logic [2:0] {
    StIdle, StNak, StAddr, StData, StReq, StAccess, StRecover, StResp
  } state_e;

  state_e          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [AccW-1:0] acc_cnt_q, acc_cnt_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;

  assign mem_addr_o = {addr_q[31:2], 2'b00};
  assign mem_data_o = data_q;

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    acc_cnt_d  = acc_cnt_q;
    to_cnt_d   = to_cnt_q;
    tx_data_o  = 8'h00;
    tx_valid_o = 1'b0;
    bus_req_o  = 1'b0;
    busy_o     = 1'b0;
    mem_ce_n   = 1'b1;
    mem_oe_n   = 1'b1;
    mem_we_n   = 1'b1;
    mem_be_n   = 4'hF;

    unique case (state_q)
      StIdle: begin
        if (rx_valid_i) begin
          if (rx_data_i == OpWrite || rx_data_i == OpRead) begin
            is_wr_d    = (rx_data_i == OpWrite);
            byte_cnt_d = 2'd0;
            to_cnt_d   = '0;
            state_d    = StAddr;
          end else begin
            state_d = StNak;
          end
        end
      end

      StNak: begin
        tx_valid_o = 1'b1;
        tx_data_o  = RspNak;
        if (tx_ready_i) state_d = StIdle;
      end

      StAddr, StData: begin
        busy_o = 1'b1;
        if (rx_valid_i) begin
          to_cnt_d   = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Shift in from the top so the first (LSB) byte ends up in [7:0].
          if (state_q == StAddr) addr_d = {rx_data_i, addr_q[31:8]};
          else                   data_d = {rx_data_i, data_q[31:8]};
          if (byte_cnt_q == 2'd3) begin
            state_d = (state_q == StAddr && is_wr_q) ? StData : StReq;
          end
        end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end

      StReq: begin
        busy_o    = 1'b1;
        bus_req_o = 1'b1;
        if (bus_gnt_i) begin
          acc_cnt_d = '0;
          state_d   = StAccess;
        end
      end

      StAccess: begin
        busy_o    = 1'b1;
        bus_req_o = 1'b1;
        mem_ce_n  = 1'b0;
        mem_be_n  = 4'h0;
        mem_we_n  = ~is_wr_q;
        mem_oe_n  = is_wr_q;
        // Grant is not re-checked: once started the access always completes.
        if (acc_cnt_q == AccW'(ACCESS_CYCLES - 1)) begin
          if (!is_wr_q) rdata_d = mem_data_i;
          state_d = StRecover;
        end else begin
          acc_cnt_d = acc_cnt_q + AccW'(1);
        end
      end

      StRecover: begin
        busy_o     = 1'b1;
        byte_cnt_d = 2'd0;
        state_d    = StResp;
      end

      StResp: begin
        busy_o     = 1'b1;
        tx_valid_o = 1'b1;
        tx_data_o  = is_wr_q ? RspAck : rdata_q[8*byte_cnt_q +: 8];
        if (tx_ready_i) begin
          if (is_wr_q || byte_cnt_q == 2'd3) state_d = StIdle;
          else byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      is_wr_q    <= 1'b0;
      byte_cnt_q <= 2'd0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      acc_cnt_q  <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      acc_cnt_q  <= acc_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

endmodule
